adc_frame_axis: RTL and testbench

ADC_FRAME_AXIS -- requirements
Module: adc_frame_axis

---
 rtl/adc_axis_pkg.sv | 19 +
 rtl/frame_fifo.sv | 68 ++++++
 rtl/adc_frame_axis.sv | 148 ++++++++++++++
 tb/tb_adc_frame_axis.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_axis_pkg.sv
// Shared types and width helpers for the ADC frame to AXI-Stream serializer.
// Imported by frame_fifo and adc_frame_axis.
package adc_axis_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ser_state_t;

  function automatic int calc_idx_w(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

  // A FIFO entry holds all channel samples plus the enable mask captured with them.
  function automatic int calc_entry_w(input int num_ch, input int data_w);
    return num_ch * data_w + num_ch;
  endfunction

endpackage

// File: rtl/frame_fifo.sv
// Whole-frame FIFO with registered full/empty flags.
// A push is accepted while full when a pop happens in the same cycle.
module frame_fifo
  import adc_axis_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + (PTR_W+1)'(1);
      2'b01:   count_nxt = count - (PTR_W+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_nxt;
      full  <= (count_nxt == (PTR_W+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/adc_frame_axis.sv
// Buffers ADC conversion frames and serializes their enabled channels
// onto an AXI-Stream master, one sample per beat, with drop statistics.
module adc_frame_axis
  import adc_axis_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [NUM_CH*DATA_W-1:0]        in_data,
  input  logic [NUM_CH-1:0]               ch_en,
  output logic [DATA_W-1:0]               m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [calc_idx_w(NUM_CH)-1:0]   m_axis_tuser,
  input  logic                            clr_stats,
  output logic                            overflow,
  output logic [CNT_W-1:0]                drop_cnt
);

  localparam int IDX_W   = calc_idx_w(NUM_CH);
  localparam int FRAME_W = NUM_CH * DATA_W;
  localparam int ENTRY_W = calc_entry_w(NUM_CH, DATA_W);
  localparam logic [NUM_CH-1:0] MASK_ONE = NUM_CH'(1);

  ser_state_t         state;
  ser_state_t         state_nxt;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic [ENTRY_W-1:0] fifo_rd;
  logic [FRAME_W-1:0] frame_data;
  logic [NUM_CH-1:0]  rem_mask;
  logic               frame_req;
  logic               drop;
  logic               beat_hs;
  logic               last_beat;
  logic [IDX_W-1:0]   cur_idx;
  logic [DATA_W-1:0]  cur_data;

  assign frame_req = in_valid && !rst && (ch_en != '0);
  assign fifo_push = frame_req && (!fifo_full || fifo_pop);
  assign drop      = frame_req && fifo_full && !fifo_pop;
  assign beat_hs   = m_axis_tvalid && m_axis_tready;
  // rem_mask holds the channels still to send; one bit left means this is the last beat.
  assign last_beat = (rem_mask & (rem_mask - MASK_ONE)) == '0;

  frame_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data ({in_data, ch_en}),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    cur_idx  = '0;
    cur_data = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rem_mask[i]) begin
        cur_idx  = IDX_W'(i);
        cur_data = frame_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = STREAM;
      STREAM:  if (beat_hs && last_beat && fifo_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The next frame is popped on the final handshake so frames stream back to back.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tuser  = '0;
    m_axis_tlast  = 1'b0;
    fifo_pop      = 1'b0;
    case (state)
      IDLE: begin
        fifo_pop = !fifo_empty;
      end
      STREAM: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = cur_data;
        m_axis_tuser  = cur_idx;
        m_axis_tlast  = last_beat;
        fifo_pop      = m_axis_tready && last_beat && !fifo_empty;
      end
      default: begin
        fifo_pop = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_data <= '0;
      rem_mask   <= '0;
    end else if (fifo_pop) begin
      frame_data <= fifo_rd[ENTRY_W-1 -: FRAME_W];
      rem_mask   <= fifo_rd[NUM_CH-1:0];
    end else if (beat_hs) begin
      rem_mask <= rem_mask & (rem_mask - MASK_ONE);
    end
  end

  // A drop in the same cycle as a clear is kept, so the clear never hides it.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_stats) begin
      overflow <= drop;
      drop_cnt <= drop ? CNT_W'(1) : '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_adc_frame_axis.sv
// Directed self-checking bench for adc_frame_axis; a second instance with a
// 2-bit drop counter shares all inputs to observe counter saturation.
module tb_adc_frame_axis;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic [3:0]  ch_en;
  logic        m_axis_tready;
  logic        clr_stats;

  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic [1:0]  m_axis_tuser;
  logic        overflow;
  logic [15:0] drop_cnt;

  logic [15:0] tdata_b;
  logic        tvalid_b;
  logic        tlast_b;
  logic [1:0]  tuser_b;
  logic        overflow_b;
  logic [1:0]  drop_cnt_b;

  int vectors    = 0;
  int miscompares = 0;

  logic [15:0] exp_data[$];
  logic [1:0]  exp_user[$];
  logic        exp_last[$];
  logic [15:0] got_data[$];
  logic [1:0]  got_user[$];
  logic        got_last[$];

  always #5 clk = ~clk;

  adc_frame_axis #(.NUM_CH(4), .DATA_W(16), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .ch_en(ch_en),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .clr_stats(clr_stats),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  adc_frame_axis #(.NUM_CH(4), .DATA_W(16), .DEPTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .ch_en(ch_en),
    .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(tlast_b),
    .m_axis_tuser(tuser_b), .clr_stats(clr_stats),
    .overflow(overflow_b), .drop_cnt(drop_cnt_b)
  );

  function automatic logic [63:0] mk_frame(input int f);
    logic [63:0] d;
    for (int k = 0; k < 4; k++) d[k*16 +: 16] = 16'((f + 1) * 256 + k);
    return d;
  endfunction

  task automatic exp_clear();
    exp_data.delete();
    exp_user.delete();
    exp_last.delete();
  endtask

  // Reference beat model: enabled channels ascending, last on the highest one.
  task automatic add_expected(input logic [63:0] d, input logic [3:0] m);
    int hi = 0;
    for (int k = 0; k < 4; k++) if (m[k]) hi = k;
    for (int k = 0; k < 4; k++) begin
      if (m[k]) begin
        exp_data.push_back(d[k*16 +: 16]);
        exp_user.push_back(2'(k));
        exp_last.push_back(k == hi);
      end
    end
  endtask

  task automatic send_frame(input logic [63:0] d, input logic [3:0] m);
    in_valid = 1'b1;
    in_data  = d;
    ch_en    = m;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(input int max_cycles, input int n_beats);
    got_data.delete();
    got_user.delete();
    got_last.delete();
    m_axis_tready = 1'b1;
    for (int i = 0; i < max_cycles && got_data.size() < n_beats; i++) begin
      if (m_axis_tvalid) begin
        got_data.push_back(m_axis_tdata);
        got_user.push_back(m_axis_tuser);
        got_last.push_back(m_axis_tlast);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bit seen;
    rst = 1'b1; in_valid = 1'b1; in_data = mk_frame(99); ch_en = 4'hF;
    m_axis_tready = 1'b1; clr_stats = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, overflow, drop_cnt} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got v=%b l=%b u=%0d d=%h ov=%b cnt=%0d, expected all zero",
               m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, overflow, drop_cnt);
    end
    vectors++;
    if ({tvalid_b, tlast_b, tuser_b, tdata_b, overflow_b, drop_cnt_b} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs_cnt2: got v=%b d=%h cnt=%0d, expected all zero",
               tvalid_b, tdata_b, drop_cnt_b);
    end
    rst = 1'b0; in_valid = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (m_axis_tvalid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ignores_in_valid: got tvalid seen=%b, expected 0", seen);
    end
  endtask

  task automatic test_single_frame();
    m_axis_tready = 1'b1;
    send_frame({16'h4444, 16'h3333, 16'h2222, 16'h1111}, 4'b1111);
    vectors++;
    if (m_axis_tvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL latency_c1: got tvalid=%b, expected 0", m_axis_tvalid);
    end
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      vectors++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'(32'h1111 * (b + 1)) ||
          m_axis_tuser !== 2'(b) || m_axis_tlast !== (b == 3)) begin
        miscompares++;
        $display("[TB] FAIL single_beat%0d: got v=%b d=%h u=%0d l=%b, expected v=1 d=%h u=%0d l=%b",
                 b, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast,
                 16'(32'h1111 * (b + 1)), b, (b == 3));
      end
      @(negedge clk);
    end
    vectors++;
    if (m_axis_tvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_idle_after: got tvalid=%b, expected 0", m_axis_tvalid);
    end
  endtask

  task automatic test_sparse_mask();
    send_frame({16'h4444, 16'h3333, 16'h2222, 16'h1111}, 4'b1010);
    collect(10, 2);
    vectors++;
    if (got_data.size() !== 2) begin
      miscompares++;
      $display("[TB] FAIL sparse_count: got %0d beats, expected 2", got_data.size());
    end else begin
      vectors++;
      if (got_data[0] !== 16'h2222 || got_user[0] !== 2'd1 || got_last[0] !== 1'b0 ||
          got_data[1] !== 16'h4444 || got_user[1] !== 2'd3 || got_last[1] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL sparse_beats: got %h/%0d/%b %h/%0d/%b, expected 2222/1/0 4444/3/1",
                 got_data[0], got_user[0], got_last[0], got_data[1], got_user[1], got_last[1]);
      end
    end
    vectors++;
    if (m_axis_tvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sparse_idle_after: got tvalid=%b, expected 0", m_axis_tvalid);
    end
  endtask

  task automatic test_zero_mask();
    bit seen = 1'b0;
    send_frame(mk_frame(30), 4'b0000);
    repeat (4) begin
      if (m_axis_tvalid) seen = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (seen !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL zero_mask: got seen=%b ov=%b cnt=%0d, expected 0 0 0", seen, overflow, drop_cnt);
    end
  endtask

  task automatic test_back_to_back();
    exp_clear();
    m_axis_tready = 1'b0;
    send_frame(mk_frame(40), 4'b1111); add_expected(mk_frame(40), 4'b1111);
    send_frame(mk_frame(41), 4'b0101); add_expected(mk_frame(41), 4'b0101);
    send_frame(mk_frame(42), 4'b1000); add_expected(mk_frame(42), 4'b1000);
    m_axis_tready = 1'b1;
    for (int i = 0; i < exp_data.size(); i++) begin
      vectors++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_data[i] ||
          m_axis_tuser !== exp_user[i] || m_axis_tlast !== exp_last[i]) begin
        miscompares++;
        $display("[TB] FAIL b2b_beat%0d: got v=%b d=%h u=%0d l=%b, expected v=1 d=%h u=%0d l=%b",
                 i, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast,
                 exp_data[i], exp_user[i], exp_last[i]);
      end
      @(negedge clk);
    end
    vectors++;
    if (m_axis_tvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_idle_after: got tvalid=%b, expected 0", m_axis_tvalid);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] prev_data;
    logic [1:0]  prev_user;
    logic        prev_last;
    bit          prev_stall;
    int          beats;
    exp_clear();
    m_axis_tready = 1'b0;
    send_frame(mk_frame(10), 4'b1111); add_expected(mk_frame(10), 4'b1111);
    send_frame(mk_frame(11), 4'b0110); add_expected(mk_frame(11), 4'b0110);
    prev_stall = 1'b0; prev_data = '0; prev_user = '0; prev_last = 1'b0;
    beats = 0;
    for (int i = 0; i < 60 && beats < exp_data.size(); i++) begin
      m_axis_tready = i[0];
      if (prev_stall) begin
        vectors++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data ||
            m_axis_tuser !== prev_user || m_axis_tlast !== prev_last) begin
          miscompares++;
          $display("[TB] FAIL stall_hold: got v=%b d=%h u=%0d l=%b, expected v=1 d=%h u=%0d l=%b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast,
                   prev_data, prev_user, prev_last);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        vectors++;
        if (m_axis_tdata !== exp_data[beats] || m_axis_tuser !== exp_user[beats] ||
            m_axis_tlast !== exp_last[beats]) begin
          miscompares++;
          $display("[TB] FAIL toggle_beat%0d: got d=%h u=%0d l=%b, expected d=%h u=%0d l=%b",
                   beats, m_axis_tdata, m_axis_tuser, m_axis_tlast,
                   exp_data[beats], exp_user[beats], exp_last[beats]);
        end
        beats++;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_user  = m_axis_tuser;
      prev_last  = m_axis_tlast;
      @(negedge clk);
    end
    vectors++;
    if (beats !== 6 || m_axis_tvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL toggle_count: got %0d beats tvalid=%b, expected 6 beats tvalid=0",
               beats, m_axis_tvalid);
    end
  endtask

  task automatic test_overflow();
    exp_clear();
    m_axis_tready = 1'b0;
    for (int f = 0; f < 6; f++) begin
      send_frame(mk_frame(f), 4'b1111);
      if (f < 5) add_expected(mk_frame(f), 4'b1111);
    end
    vectors++;
    if (overflow !== 1'b1 || drop_cnt !== 16'd1 || drop_cnt_b !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL overflow_stats: got ov=%b cnt=%0d cnt2=%0d, expected 1 1 1",
               overflow, drop_cnt, drop_cnt_b);
    end
    vectors++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tuser !== 2'd0 || m_axis_tdata !== 16'h0100) begin
      miscompares++;
      $display("[TB] FAIL overflow_stalled_head: got v=%b u=%0d d=%h, expected 1 0 0100",
               m_axis_tvalid, m_axis_tuser, m_axis_tdata);
    end
    collect(60, 20);
    vectors++;
    if (got_data.size() !== 20) begin
      miscompares++;
      $display("[TB] FAIL overflow_drain_count: got %0d beats, expected 20", got_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      vectors++;
      if (got_data[i] !== exp_data[i] || got_user[i] !== exp_user[i] || got_last[i] !== exp_last[i]) begin
        miscompares++;
        $display("[TB] FAIL overflow_beat%0d: got d=%h u=%0d l=%b, expected d=%h u=%0d l=%b",
                 i, got_data[i], got_user[i], got_last[i], exp_data[i], exp_user[i], exp_last[i]);
      end
    end
    vectors++;
    if (m_axis_tvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL overflow_idle_after: got tvalid=%b, expected 0", m_axis_tvalid);
    end
  endtask

  task automatic test_clr_stats();
    exp_clear();
    m_axis_tready = 1'b0;
    for (int f = 50; f < 55; f++) begin
      send_frame(mk_frame(f), 4'b1111);
      add_expected(mk_frame(f), 4'b1111);
    end
    clr_stats = 1'b1;
    send_frame(mk_frame(55), 4'b1111);
    clr_stats = 1'b0;
    vectors++;
    if (overflow !== 1'b1 || drop_cnt !== 16'd1 || drop_cnt_b !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL clr_with_drop: got ov=%b cnt=%0d cnt2=%0d, expected 1 1 1",
               overflow, drop_cnt, drop_cnt_b);
    end
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    vectors++;
    if (overflow !== 1'b0 || drop_cnt !== 16'd0 || drop_cnt_b !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL clr_alone: got ov=%b cnt=%0d cnt2=%0d, expected 0 0 0",
               overflow, drop_cnt, drop_cnt_b);
    end
    for (int f = 60; f < 65; f++) send_frame(mk_frame(f), 4'b1111);
    vectors++;
    if (overflow !== 1'b1 || drop_cnt !== 16'd5 || drop_cnt_b !== 2'd3) begin
      miscompares++;
      $display("[TB] FAIL drop_saturate: got ov=%b cnt=%0d cnt2=%0d, expected 1 5 3",
               overflow, drop_cnt, drop_cnt_b);
    end
    collect(60, 20);
    vectors++;
    if (got_data.size() !== 20 || got_data[0] !== exp_data[0] || got_data[19] !== exp_data[19]) begin
      miscompares++;
      $display("[TB] FAIL clr_drain: got %0d beats, expected 20 from frames 50..54", got_data.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    bit seen = 1'b0;
    m_axis_tready = 1'b1;
    send_frame(mk_frame(20), 4'b1111);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (m_axis_tvalid !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_frame: got v=%b ov=%b cnt=%0d, expected 0 0 0",
               m_axis_tvalid, overflow, drop_cnt);
    end
    repeat (4) begin
      @(negedge clk);
      if (m_axis_tvalid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_no_more_beats: got tvalid seen=%b, expected 0", seen);
    end
    send_frame(mk_frame(21), 4'b1111);
    @(negedge clk);
    vectors++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tuser !== 2'd0 || m_axis_tdata !== 16'h1600) begin
      miscompares++;
      $display("[TB] FAIL rst_restart: got v=%b u=%0d d=%h, expected 1 0 1600",
               m_axis_tvalid, m_axis_tuser, m_axis_tdata);
    end
    collect(10, 4);
    vectors++;
    if (got_data.size() !== 4 || got_data[3] !== 16'h1603 || got_last[3] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rst_restart_frame: got %0d beats, expected 4 ending 1603 with tlast",
               got_data.size());
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_sparse_mask();
    test_zero_mask();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_clr_stats();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
